// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the synchronous level-tracking FIFO.
package sync_fifo_pkg;

  localparam int unsigned SF_DSIZE = 8;
  localparam int unsigned SF_ASIZE = 4;

  // Level / pointer type for the default configuration (ASIZE+1 bits).
  typedef logic [SF_ASIZE:0] sf_level_t;

  // Number of words addressed by asize address bits.
  function automatic int unsigned sf_depth(input int unsigned asize);
    return 32'(1) << asize;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE storage: synchronous write port, combinational read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = SF_DSIZE,
  parameter int unsigned ASIZE = SF_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = sf_depth(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Show-ahead read of the addressed word.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with registered level count and level-derived flags.
// Optional sticky overflow/underflow detection: define SYNC_FIFO_ERR_EN.
module sync_fifo_level
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = SF_DSIZE,
  parameter int unsigned ASIZE     = SF_ASIZE,
  parameter int unsigned AF_THRESH = sf_depth(ASIZE) - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = sf_depth(ASIZE);

  typedef logic [ASIZE:0] lvl_t;

  localparam lvl_t DEPTH_L = lvl_t'(DEPTH);

  // Reject illegal threshold ordering at elaboration.
  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
    $fatal(1, "sync_fifo_level: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
  end

  lvl_t wptr_q, wptr_d;
  lvl_t rptr_q, rptr_d;
  lvl_t level_q, level_d;
  logic rempty_q, rempty_d;
  logic wfull_q, wfull_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;

  logic rd_acc_c;
  logic wr_acc_c;
  logic mem_we_c;

  // Accept logic, pointer/level update and next-cycle flags.
  always_comb begin
    rd_acc_c = rinc & ~rempty_q;
    wr_acc_c = winc & (~wfull_q | rd_acc_c);
    mem_we_c = wr_acc_c & ~clear;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;

    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      wptr_d  = wptr_q + lvl_t'(wr_acc_c);
      rptr_d  = rptr_q + lvl_t'(rd_acc_c);
      level_d = level_q + lvl_t'(wr_acc_c) - lvl_t'(rd_acc_c);
    end

    // Flags are registered alongside level so both change on the same edge.
    rempty_d = (level_d == '0);
    wfull_d  = (level_d == DEPTH_L);
    afull_d  = (32'(level_d) >= AF_THRESH);
    aempty_d = (32'(level_d) <= AE_THRESH);
  end

  // Pointer, level and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      rempty_q <= 1'b1;
      wfull_q  <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      rempty_q <= rempty_d;
      wfull_q  <= wfull_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (rdata)
  );

  assign level        = level_q;
  assign rempty       = rempty_q;
  assign wfull        = wfull_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; a flush clears them.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | (winc & ~wr_acc_c);
      unf_d = unf_q | (rinc & ~rd_acc_c);
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level (default parameters).
module tb_sync_fifo_level;

  localparam int DEPTH = 16;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty;
  logic [4:0] level;
  logic       overflow, underflow;

  sync_fifo_level dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .rdata        (rdata),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word queue plus sticky error bits.
  logic [7:0] mq[$];
  bit m_ovf, m_unf;

  typedef struct {
    bit         c;
    bit         w;
    bit         r;
    logic [7:0] d;
    int         lvl;
    bit         emp;
    bit         full;
    logic [7:0] rd;
  } vec_t;

  vec_t vt[8];

  function automatic void chk(string nm, int unsigned act, int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_model(string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".level"}, 32'(level), sz);
    chk({tag, ".rempty"}, 32'(rempty), 32'(sz == 0));
    chk({tag, ".wfull"}, 32'(wfull), 32'(sz == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= DEPTH - 2));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= 2));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ERR_EN & m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(ERR_EN & m_unf));
    if (sz > 0) chk({tag, ".rdata"}, 32'(rdata), 32'(mq[0]));
  endfunction

  // One clock of stimulus, model update, and check.
  task automatic step(input bit c, input bit w, input bit r, input logic [7:0] d, input string tag);
    bit racc, wacc;
    int sz;
    clear = c; winc = w; rinc = r; wdata = d;
    sz   = mq.size();
    racc = r && (sz > 0);
    wacc = w && ((sz < DEPTH) || racc);
    @(posedge clk);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_unf = 1'b1;
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(d);
    end
    #1;
    clear = 1'b0; winc = 1'b0; rinc = 1'b0;
    check_model(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".level"}, 32'(level), 0);
    chk({tag, ".rempty"}, 32'(rempty), 1);
    chk({tag, ".wfull"}, 32'(wfull), 0);
    chk({tag, ".almost_empty"}, 32'(almost_empty), 1);
    chk({tag, ".almost_full"}, 32'(almost_full), 0);
    chk({tag, ".overflow"}, 32'(overflow), 0);
    chk({tag, ".underflow"}, 32'(underflow), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wbias;
    int rbias;

    vt[0] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h11};
    vt[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h11};
    vt[2] = '{1'b0, 1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b0, 8'h22};
    vt[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h33};
    vt[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00};
    vt[5] = '{1'b0, 1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b0, 8'h44};
    vt[6] = '{1'b1, 1'b1, 1'b0, 8'h55, 0, 1'b1, 1'b0, 8'h00};
    vt[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00};

    do_reset();

    // Table-driven basic behaviour.
    for (int i = 0; i < 8; i++) begin
      step(vt[i].c, vt[i].w, vt[i].r, vt[i].d, "vec");
      chk("vec.level_tbl", 32'(level), 32'(vt[i].lvl));
      chk("vec.rempty_tbl", 32'(rempty), 32'(vt[i].emp));
      chk("vec.wfull_tbl", 32'(wfull), 32'(vt[i].full));
      if (vt[i].lvl > 0) chk("vec.rdata_tbl", 32'(rdata), 32'(vt[i].rd));
    end

    // Fill to full; almost_full from level 14; 17th write dropped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i), "fill");
      chk("fill.af_tbl", 32'(almost_full), 32'(i + 1 >= 14));
    end
    chk("fill.wfull_const", 32'(wfull), 1);
    step(1'b0, 1'b1, 1'b0, 8'h77, "fill17");
    chk("fill17.level_const", 32'(level), 16);
    chk("fill17.ovf_const", 32'(overflow), 32'(ERR_EN));

    // Drain in order, then an extra read.
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.rdata_const", 32'(rdata), i);
      step(1'b0, 1'b0, 1'b1, 8'h00, "drain");
    end
    chk("drain.rempty_const", 32'(rempty), 1);
    step(1'b0, 1'b0, 1'b1, 8'h00, "drain_extra");
    chk("drain_extra.unf_const", 32'(underflow), 32'(ERR_EN));

    // Write-through at full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i), "refill");
    step(1'b0, 1'b1, 1'b1, 8'hAA, "wthru");
    chk("wthru.level_const", 32'(level), 16);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("wthru.last_const", 32'(rdata), 32'h0AA);
      step(1'b0, 1'b0, 1'b1, 8'h00, "wthru_drain");
    end

    // Simultaneous write/read while empty.
    step(1'b0, 1'b1, 1'b1, 8'h55, "empty_wr");
    chk("empty_wr.level_const", 32'(level), 1);
    chk("empty_wr.rdata_const", 32'(rdata), 32'h055);
    chk("empty_wr.unf_const", 32'(underflow), 32'(ERR_EN));

    // 40 write/read pairs across pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i), "wrap_pre");
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(i), "wrap");
      if (32'(level) > 16) chk("wrap.level_bound", 32'(level), 16);
    end
    while (mq.size() > 0) step(1'b0, 1'b0, 1'b1, 8'h00, "wrap_drain");

    // Flush at level 9 with a concurrent write.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), "pre_clr");
    step(1'b1, 1'b1, 1'b0, 8'hEE, "clr");
    chk("clr.level_const", 32'(level), 0);
    chk("clr.rempty_const", 32'(rempty), 1);
    chk("clr.ae_const", 32'(almost_empty), 1);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), "pre_rst");
    winc = 1'b1; wdata = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    winc = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h3C, "resume");
    chk("resume.rdata_const", 32'(rdata), 32'h03C);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        wbias = (i % 200 == 0) ? 75 : 30;
        rbias = 100 - wbias;
      end
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 99) < wbias),
           ($urandom_range(0, 99) < rbias), 8'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
